// File: rtl/vec_mem_stage.sv
// vec_mem_stage: memory stage behind the vec_cpu execute register.
// Sequences scalar and 64-bit vector loads/stores over a 32-bit word-addressed bus.
// Ports:
//   clk, reset (async, active-low)
//   start, mem_op[1:0], base_addr, st_scalar, st_vec   : latched op request
//   stride[7:0]                                         : beat address step (VEC_MEM_STRIDE_EN only)
//   mem_data                                            : memory read data, MEM_RD_LAT after cpu_addr
//   wr_enable, cpu_addr, cpu_data                       : memory bus
//   busy, mem_rdy                                       : status / one-cycle completion pulse
//   ld_scalar, ld_vec                                   : last scalar / vector load results
// Optional feature: define VEC_MEM_STRIDE_EN to add the stride input (otherwise stride is 1).
module vec_mem_stage #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned VEC_W      = 64,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mem_op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] st_scalar,
  input  logic [VEC_W-1:0]  st_vec,
`ifdef VEC_MEM_STRIDE_EN
  input  logic [7:0]        stride,
`endif
  input  logic [DATA_W-1:0] mem_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              busy,
  output logic              mem_rdy,
  output logic [DATA_W-1:0] ld_scalar,
  output logic [VEC_W-1:0]  ld_vec
);

  localparam int unsigned BEATS  = VEC_W / DATA_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAT_W  = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RDWAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   st_scalar_q;
  logic [VEC_W-1:0]    st_vec_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [LAT_W-1:0]    wait_q;
  logic [DATA_W-1:0]   ld_scalar_q;
  logic [VEC_W-1:0]    ld_vec_q;
  logic [ADDR_W-1:0]   step;
  logic [ADDR_W-1:0]   beat_addr;
  logic                is_vec, is_store, last_beat, wait_done;

`ifdef VEC_MEM_STRIDE_EN
  logic [7:0]          stride_q;
  assign step = ADDR_W'(stride_q);
`else
  assign step = ADDR_W'(1);
`endif

  // mem_op: bit 1 selects vector, bit 0 selects store
  assign is_vec    = op_q[1];
  assign is_store  = op_q[0];
  assign last_beat = !is_vec || (beat_q == BEAT_W'(BEATS - 1));
  assign wait_done = (wait_q == LAT_W'(MEM_RD_LAT - 1));
  // Scalar ops always sit at beat 0, so the stride never affects them
  assign beat_addr = base_q + ADDR_W'(beat_q) * step;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADDR;
      ADDR:    if (!is_store)     state_d = RDWAIT;
               else if (last_beat) state_d = DONE;
      RDWAIT:  if (wait_done) state_d = last_beat ? DONE : ADDR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic (Moore: depends on registered state only)
  always_comb begin
    wr_enable = 1'b0;
    cpu_addr  = '0;
    cpu_data  = '0;
    mem_rdy   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      ADDR: begin
        cpu_addr = beat_addr;
        if (is_store) begin
          wr_enable = 1'b1;
          cpu_data  = is_vec ? st_vec_q[32'(beat_q) * DATA_W +: DATA_W] : st_scalar_q;
        end
      end
      RDWAIT:  cpu_addr = beat_addr;
      DONE:    mem_rdy  = 1'b1;
      default: ;
    endcase
  end

  assign ld_scalar = ld_scalar_q;
  assign ld_vec    = ld_vec_q;

  // Op latch, beat/wait counters and load result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      base_q      <= '0;
      st_scalar_q <= '0;
      st_vec_q    <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      ld_scalar_q <= '0;
      ld_vec_q    <= '0;
`ifdef VEC_MEM_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q        <= mem_op;
          base_q      <= base_addr;
          st_scalar_q <= st_scalar;
          st_vec_q    <= st_vec;
          beat_q      <= '0;
          wait_q      <= '0;
`ifdef VEC_MEM_STRIDE_EN
          stride_q    <= stride;
`endif
        end
        ADDR: begin
          wait_q <= '0;
          if (is_store && !last_beat) beat_q <= beat_q + BEAT_W'(1);
        end
        RDWAIT: begin
          if (wait_done) begin
            wait_q <= '0;
            if (is_vec) ld_vec_q[32'(beat_q) * DATA_W +: DATA_W] <= mem_data;
            else        ld_scalar_q <= mem_data;
            if (!last_beat) beat_q <= beat_q + BEAT_W'(1);
          end else begin
            wait_q <= wait_q + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Self-checking bench for vec_mem_stage: a per-cycle expectation queue built from the
// latency/hold rules, plus directed operations with literal expected values.
module tb_vec_mem_stage;

  localparam int unsigned L = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mem_op;
  logic [31:0] base_addr;
  logic [31:0] st_scalar;
  logic [63:0] st_vec;
  logic [31:0] mem_data;
  logic        wr_enable;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        busy;
  logic        mem_rdy;
  logic [31:0] ld_scalar;
  logic [63:0] ld_vec;
`ifdef VEC_MEM_STRIDE_EN
  logic [7:0]  stride;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_mem_stage #(.ADDR_W(32), .DATA_W(32), .VEC_W(64), .MEM_RD_LAT(L)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mem_op(mem_op),
    .base_addr(base_addr),
    .st_scalar(st_scalar),
    .st_vec(st_vec),
`ifdef VEC_MEM_STRIDE_EN
    .stride(stride),
`endif
    .mem_data(mem_data),
    .wr_enable(wr_enable),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .busy(busy),
    .mem_rdy(mem_rdy),
    .ld_scalar(ld_scalar),
    .ld_vec(ld_vec)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: word array with MEM_RD_LAT read pipeline
  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_s;
  logic [31:0] pipe [L];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge clk) addr_s <= cpu_addr;
  always @(posedge clk) begin
    pipe[0] <= rd(addr_s);
    for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[L-1];

  // Write log for literal checks
  logic [63:0] wq [$];
  always @(negedge clk) if (reset && wr_enable) wq.push_back({cpu_addr, cpu_data});

  // Model: one expectation entry per busy cycle; empty queue means IDLE
  typedef struct {
    logic        busy, we, rdy, chk_data, chk_v, set_s, set_v;
    logic [31:0] addr, data, ld_s;
    logic [63:0] ld_v;
  } exp_t;

  exp_t q [$];
  logic [31:0] m_ld_s;
  logic [63:0] m_ld_v;

  function automatic exp_t mk(input logic b, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic cd, input logic r, input logic cv);
    exp_t e;
    e.busy = b; e.we = we; e.addr = a; e.data = d; e.chk_data = cd; e.rdy = r; e.chk_v = cv;
    e.set_s = 1'b0; e.set_v = 1'b0; e.ld_s = '0; e.ld_v = '0;
    return e;
  endfunction

  function automatic void push_op(input logic [1:0] op, input logic [31:0] base,
                                  input logic [31:0] sc, input logic [63:0] vec, input int unsigned strd);
    exp_t e;
    int beats = op[1] ? 2 : 1;
    logic [31:0] a;
    logic [63:0] v = '0;
    for (int b = 0; b < beats; b++) begin
      a = base + 32'(b) * strd;
      if (op[0]) begin
        q.push_back(mk(1, 1, a, op[1] ? (b == 0 ? vec[31:0] : vec[63:32]) : sc, 1, 0, 1));
      end else begin
        for (int c = 0; c <= int'(L); c++) q.push_back(mk(1, 0, a, 0, 0, 0, !op[1]));
        if (b == 0) v[31:0] = rd(a); else v[63:32] = rd(a);
      end
    end
    e = mk(1, 0, 0, 0, 1, 1, 1);
    if (!op[0] && !op[1]) begin e.set_s = 1'b1; e.ld_s = rd(base); end
    if (!op[0] &&  op[1]) begin e.set_v = 1'b1; e.ld_v = v; end
    q.push_back(e);
  endfunction

  // Compare process
  always @(negedge clk) begin
    exp_t e;
    logic was_idle;
    int unsigned cur_stride;
    if (!reset) begin
      q.delete();
      m_ld_s = '0;
      m_ld_v = '0;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_we", 64'(wr_enable), 0);
      chk("rst_addr", 64'(cpu_addr), 0);
      chk("rst_data", 64'(cpu_data), 0);
      chk("rst_rdy", 64'(mem_rdy), 0);
      chk("rst_ld_s", 64'(ld_scalar), 0);
      chk("rst_ld_v", ld_vec, 0);
    end else begin
      was_idle = (q.size() == 0);
      e = was_idle ? mk(0, 0, 0, 0, 1, 0, 1) : q.pop_front();
      if (e.set_s) m_ld_s = e.ld_s;
      if (e.set_v) m_ld_v = e.ld_v;
      chk("busy", 64'(busy), 64'(e.busy));
      chk("wr_enable", 64'(wr_enable), 64'(e.we));
      chk("cpu_addr", 64'(cpu_addr), 64'(e.addr));
      if (e.chk_data) chk("cpu_data", 64'(cpu_data), 64'(e.data));
      chk("mem_rdy", 64'(mem_rdy), 64'(e.rdy));
      chk("ld_scalar", 64'(ld_scalar), 64'(m_ld_s));
      if (e.chk_v) chk("ld_vec", ld_vec, m_ld_v);
`ifdef VEC_MEM_STRIDE_EN
      cur_stride = 32'(stride);
`else
      cur_stride = 1;
`endif
      if (was_idle && start) push_op(mem_op, base_addr, st_scalar, st_vec, cur_stride);
    end
  end

  // Issue one op at posedge+1; returns at posedge+1 of the mem_rdy cycle (or on timeout)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] sc,
                        input logic [63:0] vec, input int exp_lat, input bit hold, input string name);
    int cnt = 0;
    start = 1'b1; mem_op = op; base_addr = a; st_scalar = sc; st_vec = vec;
    while (cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
      if (!hold) start = 1'b0;
      if (mem_rdy) break;
    end
    chk(name, 64'(cnt), 64'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; mem_op = '0; base_addr = '0; st_scalar = '0; st_vec = '0;
`ifdef VEC_MEM_STRIDE_EN
    stride = 8'd1;
`endif
    mem[32'h20] = 32'hAAAA0001;
    mem[32'h21] = 32'hBBBB0002;
    mem[32'h40] = 32'h12345678;
    mem[32'h41] = 32'hCAFEF00D;

    // 1. reset, then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 0);

    // 2. scalar store
    wq.delete();
    run_op(2'b01, 32'h10, 32'hDEADBEEF, 64'h0, 2, 0, "lat_sst");
    chk("sst_nwr", 64'(wq.size()), 1);
    if (wq.size() >= 1) chk("sst_wr", wq[0], 64'h00000010_DEADBEEF);
    @(posedge clk); #1;

    // 3. vector store with address wrap
    wq.delete();
    run_op(2'b11, 32'hFFFFFFFF, 32'h0, 64'h11112222_33334444, 3, 0, "lat_vst");
    chk("vst_nwr", 64'(wq.size()), 2);
    if (wq.size() >= 2) begin
      chk("vst_wr0", wq[0], 64'hFFFFFFFF_33334444);
      chk("vst_wr1", wq[1], 64'h00000000_11112222);
    end
    @(posedge clk); #1;

    // 4. vector load
    run_op(2'b10, 32'h20, 32'h0, 64'h0, 3 + 2 * L, 0, "lat_vld");
    chk("vld_val", ld_vec, 64'hBBBB0002_AAAA0001);
    chk("vld_ld_s", 64'(ld_scalar), 0);
    @(posedge clk); #1;

    // 5. scalar load with start held, second load aborted by reset in RDWAIT
    run_op(2'b00, 32'h40, 32'h0, 64'h0, 2 + L, 1, "lat_sld");
    chk("sld_val", 64'(ld_scalar), 64'h12345678);
    base_addr = 32'h41;
    @(posedge clk); #1;
    chk("hold_idle", 64'(busy), 0);
    @(posedge clk); #1;
    chk("hold_acc", 64'(busy), 1);
    chk("hold_addr", 64'(cpu_addr), 64'h41);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_rdy", 64'(mem_rdy), 0);
    chk("abort_ld_s", 64'(ld_scalar), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_abort_rdy", 64'(mem_rdy), 0);
    end

    // Hold rules: vector load leaves ld_scalar alone
    run_op(2'b00, 32'h40, 32'h0, 64'h0, 2 + L, 0, "lat_sld2");
    @(posedge clk); #1;
    run_op(2'b10, 32'h20, 32'h0, 64'h0, 3 + 2 * L, 0, "lat_vld2");
    chk("vld2_val", ld_vec, 64'hBBBB0002_AAAA0001);
    chk("vld2_ld_s", 64'(ld_scalar), 64'h12345678);
    @(posedge clk); #1;

`ifdef VEC_MEM_STRIDE_EN
    // 6. strided vector stores
    wq.delete();
    stride = 8'd4;
    run_op(2'b11, 32'h100, 32'h0, 64'h55556666_77778888, 3, 0, "lat_str4");
    if (wq.size() >= 2) begin
      chk("str4_a0", 64'(wq[0][63:32]), 64'h100);
      chk("str4_a1", 64'(wq[1][63:32]), 64'h104);
    end else chk("str4_nwr", 64'(wq.size()), 2);
    @(posedge clk); #1;
    wq.delete();
    stride = 8'd0;
    run_op(2'b11, 32'h100, 32'h0, 64'h55556666_77778888, 3, 0, "lat_str0");
    if (wq.size() >= 2) begin
      chk("str0_a0", 64'(wq[0][63:32]), 64'h100);
      chk("str0_a1", 64'(wq[1][63:32]), 64'h100);
    end else chk("str0_nwr", 64'(wq.size()), 2);
    stride = 8'd1;
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
